mouse_bus_reader: RTL
=====================

// Module: mouse_bus_reader
// PURPOSE
//  Bus initiator for the mouse peripheral: services its interrupt by acking it, then reads status,
//  X and Y over the shared microprocessor bus. Sits beside the CPU on BUS_ADDR/BUS_DATA/BUS_WE and
//  arbitrates via REQ/GNT. Presents an atomic {status,X,Y} sample plus a one-cycle NEW_SAMPLE strobe.
// PARAMETERS
//  MOUSE_BASE_ADDR  8'hA0   status @base, X @base+1, Y @base+2
//  READ_LATENCY     1       edges from address valid to BUS_DATA valid (peripheral registers once)
//  POLL_PERIOD      50000   CLK cycles between forced reads (MOUSE_READER_POLL_EN only)
// PORTS
//  CLK                  in     1  system clock
//  RESET_N              in     1  asynchronous, active-low reset
//  BUS_REQ              out    1  request bus ownership
//  BUS_GNT              in     1  ownership granted; sampled every edge
//  BUS_ADDR             inout  8  driven only while owning, else Z
//  BUS_WE               inout  1  driven 0 while owning, else Z
//  BUS_DATA             inout  8  never driven (always Z); sampled on capture edge
//  BUS_INTERRUPT_RAISE  in     1  level interrupt from mouse peripheral
//  BUS_INTERRUPT_ACK    out    1  one-cycle ack pulse
//  MOUSE_STATUS         out    4  last committed status[3:0]
//  MOUSE_X / MOUSE_Y    out  8+8  last committed X / Y
//  NEW_SAMPLE           out    1  one-cycle strobe, outputs updated same cycle
//  BUSY                 out    1  high in any state except IDLE
// BEHAVIOUR
//  Reset: FSM=IDLE; BUS_REQ, BUS_INTERRUPT_ACK, NEW_SAMPLE, BUSY = 0; sample outputs = 0; bus pins Z.
//  FSM: IDLE -> REQ -> ACK -> RD(idx 0..2) -> COMMIT -> IDLE.
//   IDLE: RAISE=1 at an edge -> REQ. BUS_REQ asserted from REQ until COMMIT exits.
//   REQ: wait for GNT=1 -> ACK. ACK: BUS_INTERRUPT_ACK=1 for exactly one cycle -> RD idx0.
//   RD: drive BUS_ADDR=base+idx, BUS_WE=0 for READ_LATENCY+1 cycles; BUS_DATA captured into shadow
//    reg at closing edge of last cycle; idx0 keeps [3:0] only. idx2 done -> COMMIT.
//   COMMIT: shadow -> outputs, NEW_SAMPLE=1, bus released (REQ=0, pins Z) -> IDLE.
//  Latency (L=1, GNT already high): RAISE sampled at E0; ACK in cycle 2; NEW_SAMPLE in cycle 9.
//  Ownership: ADDR/WE driven only in ACK/RD with GNT=1. GNT drop in RD: pins Z at once, wait counter
//   reset, current idx re-read from its first cycle on regrant; captured shadow entries kept.
//   GNT drop in ACK: ack still pulses (ack is a private line).
//  RAISE still/again high in COMMIT: next IDLE cycle restarts (no sample lost, none merged).
//  RAISE high during RD: ignored until IDLE; the sample read is the newest present at read time.
//  Partial samples never visible: outputs change only in COMMIT.
//  RESET_N low mid-transaction: immediate return to reset state; pins Z asynchronously.
// CONFIGURATION
//  MOUSE_READER_POLL_EN defined: free-running counter 0..POLL_PERIOD-1; wrap while IDLE starts a
//   transaction without ACK (REQ -> RD idx0); wrap while BUSY is dropped, not queued; counter restarts
//   at 0 on every COMMIT. Interrupt path unchanged.
//  Undefined: no counter, reads are interrupt-driven only.
// STRUCTURE
//  Shared package mouse_bus_pkg: register offsets (STATUS=0, X=1, Y=2), default base 8'hA0,
//   FSM state encoding, bus idle constants. Used by this block and by the mouse peripheral.
//  One sub-module: mouse_poll_timer (counter + wrap pulse), instantiated only under the macro.
// TESTING
//  1 GNT tied 1, bus model returns 05/3C/A7 at A0/A1/A2 with 1-edge latency, pulse RAISE ->
//    one ACK in cycle 2, NEW_SAMPLE in cycle 9, STATUS=5, X=3C, Y=A7, bus Z afterwards.
//  2 GNT held 0 for 20 cycles after RAISE -> BUS_REQ high, ADDR/WE Z, no ACK until GNT rises.
//  3 Drop GNT for 3 cycles during X read -> X re-read from A1, final X correct, no extra ACK.
//  4 Keep RAISE high through COMMIT (peripheral re-raises) -> second full transaction immediately,
//    two NEW_SAMPLE strobes, two ACKs.
//  5 Assert RESET_N=0 mid-RD(Y) -> all outputs 0, pins Z same cycle; old values not committed.
//  6 MOUSE_READER_POLL_EN, POLL_PERIOD=100, RAISE held 0 -> NEW_SAMPLE every ~100+9 cycles, no ACK.

Source files
------------

// File: rtl/mouse_bus_pkg.sv
// Shared definitions for the mouse peripheral and its bus reader:
// register map, default base, FSM encoding and bus idle values.
package mouse_bus_pkg;

    localparam logic [7:0] MOUSE_BASE_DEFAULT = 8'hA0;

    localparam logic [1:0] REG_STATUS = 2'd0;
    localparam logic [1:0] REG_X      = 2'd1;
    localparam logic [1:0] REG_Y      = 2'd2;

    localparam logic [7:0] BUS_ADDR_IDLE = 8'hzz;
    localparam logic       BUS_WE_IDLE   = 1'bz;
    localparam logic       BUS_WE_READ   = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_ACK,
        ST_RD,
        ST_COMMIT
    } mouse_state_e;

    function automatic logic [7:0] reg_addr(
        input logic [7:0] base,
        input logic [1:0] idx
    );
        return base + {6'd0, idx};
    endfunction

endpackage

// File: rtl/mouse_poll_timer.sv
// Free-running poll counter for the mouse bus reader; WRAP is high on
// the last count. CLEAR restarts it from zero.
module mouse_poll_timer #(
    parameter int unsigned PERIOD = 50000
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic CLEAR,
    output logic WRAP
);

    localparam int unsigned W = (PERIOD > 2) ? $clog2(PERIOD) : 1;
    localparam logic [W-1:0] LAST = W'(PERIOD - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt <= '0;
        end else if (CLEAR || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign WRAP = (cnt == LAST);

endmodule

// File: rtl/mouse_bus_reader.sv
// Bus initiator that acks the mouse interrupt and reads status/X/Y.
// Optional periodic polling when MOUSE_READER_POLL_EN is defined.
import mouse_bus_pkg::*;

module mouse_bus_reader #(
    parameter logic [7:0]  MOUSE_BASE_ADDR = MOUSE_BASE_DEFAULT,
    parameter int unsigned READ_LATENCY    = 1,
    parameter int unsigned POLL_PERIOD     = 50000
) (
    input  logic       CLK,
    input  logic       RESET_N,
    output logic       BUS_REQ,
    input  logic       BUS_GNT,
    inout  wire  [7:0] BUS_ADDR,
    inout  wire        BUS_WE,
    inout  wire  [7:0] BUS_DATA,
    input  logic       BUS_INTERRUPT_RAISE,
    output logic       BUS_INTERRUPT_ACK,
    output logic [3:0] MOUSE_STATUS,
    output logic [7:0] MOUSE_X,
    output logic [7:0] MOUSE_Y,
    output logic       NEW_SAMPLE,
    output logic       BUSY
);

    localparam int unsigned LW = $clog2(READ_LATENCY + 2);
    localparam logic [LW-1:0] LAST_WAIT = LW'(READ_LATENCY);

    mouse_state_e state;
    logic [1:0]    idx;
    logic [LW-1:0] wait_cnt;
    logic          poll_txn;
    logic [3:0]    status_sh;
    logic [7:0]    x_sh;
    logic          own;
    logic          poll_wrap;

`ifdef MOUSE_READER_POLL_EN
    mouse_poll_timer #(
        .PERIOD(POLL_PERIOD)
    ) u_poll (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .CLEAR   (state == ST_COMMIT),
        .WRAP    (poll_wrap)
    );
`else
    assign poll_wrap = 1'b0;
`endif

    // Pins follow the grant combinationally so a revoked grant frees the bus at once.
    assign own      = BUS_GNT && (state == ST_ACK || state == ST_RD);
    assign BUS_ADDR = own ? reg_addr(MOUSE_BASE_ADDR, idx) : BUS_ADDR_IDLE;
    assign BUS_WE   = own ? BUS_WE_READ : BUS_WE_IDLE;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state             <= ST_IDLE;
            idx               <= REG_STATUS;
            wait_cnt          <= '0;
            poll_txn          <= 1'b0;
            status_sh         <= '0;
            x_sh              <= '0;
            BUS_REQ           <= 1'b0;
            BUS_INTERRUPT_ACK <= 1'b0;
            NEW_SAMPLE        <= 1'b0;
            BUSY              <= 1'b0;
            MOUSE_STATUS      <= '0;
            MOUSE_X           <= '0;
            MOUSE_Y           <= '0;
        end else begin
            BUS_INTERRUPT_ACK <= 1'b0;
            NEW_SAMPLE        <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (BUS_INTERRUPT_RAISE || poll_wrap) begin
                        state    <= ST_REQ;
                        poll_txn <= !BUS_INTERRUPT_RAISE;
                        BUS_REQ  <= 1'b1;
                        BUSY     <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (BUS_GNT) begin
                        idx      <= REG_STATUS;
                        wait_cnt <= '0;
                        if (poll_txn) begin
                            state <= ST_RD;
                        end else begin
                            state             <= ST_ACK;
                            BUS_INTERRUPT_ACK <= 1'b1;
                        end
                    end
                end
                ST_ACK: begin
                    state <= ST_RD;
                end
                ST_RD: begin
                    if (!BUS_GNT) begin
                        wait_cnt <= '0;
                    end else if (wait_cnt != LAST_WAIT) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end else begin
                        wait_cnt <= '0;
                        idx      <= idx + 2'd1;
                        unique case (idx)
                            REG_STATUS: status_sh <= BUS_DATA[3:0];
                            REG_X:      x_sh      <= BUS_DATA;
                            default: begin
                                MOUSE_STATUS <= status_sh;
                                MOUSE_X      <= x_sh;
                                MOUSE_Y      <= BUS_DATA;
                                NEW_SAMPLE   <= 1'b1;
                                BUS_REQ      <= 1'b0;
                                state        <= ST_COMMIT;
                            end
                        endcase
                    end
                end
                ST_COMMIT: begin
                    state <= ST_IDLE;
                    BUSY  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
